// File: rtl/counter_step_arbiter.sv
// Round-robin sequencer for a shared 2-bit step counter: grants one requester,
// drives the step enable for the granted run length, then reports the final count.
module counter_step_arbiter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [CNT_W-1:0] len0,
  input  logic [CNT_W-1:0] len1,
  input  logic [1:0]       s_in,
  output logic             x,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [1:0]       done,
  output logic             abort,
  output logic [1:0]       fin_s
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic             x_q;
  logic [1:0]       gnt_q;
  logic             busy_q;
  logic [1:0]       done_q;
  logic             abort_q;
  logic [1:0]       fin_s_q;
  logic [CNT_W-1:0] rem_q;
  logic             last_q;

  logic             win_d;
  logic [CNT_W-1:0] win_len_d;
  logic             req_g_d;

  // On contention the requester not served last wins; otherwise the lone requester.
  always_comb begin
    win_d = req[1];
    if (req == 2'b11) begin
      win_d = ~last_q;
    end
    win_len_d = win_d ? len1 : len0;
    req_g_d   = gnt_q[1] ? req[1] : req[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= 1'b0;
      gnt_q   <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 2'b00;
      abort_q <= 1'b0;
      fin_s_q <= 2'b00;
      rem_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      done_q <= 2'b00;
      case (state_q)
        IDLE: begin
          if (req != 2'b00) begin
            gnt_q   <= win_d ? 2'b10 : 2'b01;
            last_q  <= win_d;
            rem_q   <= win_len_d;
            busy_q  <= 1'b1;
            abort_q <= 1'b0;
            if (win_len_d == '0) begin
              state_q <= DONE;
              x_q     <= 1'b0;
              done_q  <= win_d ? 2'b10 : 2'b01;
            end else begin
              state_q <= RUN;
              x_q     <= 1'b1;
            end
          end
        end
        RUN: begin
          if (!req_g_d) begin
            state_q <= DONE;
            x_q     <= 1'b0;
            abort_q <= 1'b1;
            done_q  <= gnt_q;
          end else begin
            // RUN is only entered with rem_q >= 1 and left at 1, so this never wraps.
            rem_q <= rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              state_q <= DONE;
              x_q     <= 1'b0;
              done_q  <= gnt_q;
            end
          end
        end
        DONE: begin
          fin_s_q <= s_in;
          gnt_q   <= 2'b00;
          busy_q  <= 1'b0;
          abort_q <= 1'b0;
          rem_q   <= '0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          x_q     <= 1'b0;
          gnt_q   <= 2'b00;
          busy_q  <= 1'b0;
          abort_q <= 1'b0;
          rem_q   <= '0;
        end
      endcase
    end
  end

  assign x     = x_q;
  assign gnt   = gnt_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign abort = abort_q;
  assign fin_s = fin_s_q;

endmodule
